// File: rtl/branch_resolve_unit_if.sv
// Branch request / PC redirect bundle for branch_resolve_unit.
// master drives branch ops and pc_ready; slave is the resolve unit.
interface branch_resolve_unit_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 16,
  parameter int COND_W   = 4
);
  logic                br_valid;
  logic                br_ready;
  logic [COND_W-1:0]   br_cond;
  logic [ADDR_W-1:0]   br_pc;
  logic [OFFSET_W-1:0] br_offset;
  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                pc_ready;

  modport master (
    output br_valid, br_cond, br_pc, br_offset, pc_ready,
    input  br_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  br_valid, br_cond, br_pc, br_offset, pc_ready,
    output br_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve: flag register, condition eval, redirect handshake, flush.
// Optional BRANCH_STATS_EN adds stat_resolved / stat_taken counters.
module branch_resolve_unit #(
  parameter int ADDR_W       = 32,
  parameter int OFFSET_W     = 16,
  parameter int COND_W       = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int FLAG_BYPASS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic [3:0] flags_in,
  branch_resolve_unit_if.slave bus,
  output logic       flush_o,
  output logic [3:0] flags_q,
  output logic       illegal_cond
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_taken
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rv_q;
  logic [ADDR_W-1:0] rpc_q;
  logic              flush_q;
  logic              ill_q;

  logic [3:0]        f_eff;
  logic              f_v, f_s, f_z, f_c;
  logic              taken;
  logic              illegal;
  logic              accept;
  logic [ADDR_W-1:0] target;

  assign bus.br_ready       = (state_q == IDLE);
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign flush_o            = flush_q;
  assign illegal_cond       = ill_q;

  assign accept = bus.br_valid && bus.br_ready;

  // bypass lets a flag-setting op and a dependent branch share a cycle
  assign f_eff = (FLAG_BYPASS != 0 && flag_we) ? flags_in : flags_q;
  assign {f_v, f_s, f_z, f_c} = f_eff;

  assign target = bus.br_pc
                + (ADDR_W'($signed(bus.br_offset)) << 2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (bus.br_cond >= COND_W'(12)) begin
      illegal = 1'b1;
    end else begin
      case (bus.br_cond[3:0])
        4'd1:    taken = f_s;
        4'd2:    taken = f_z;
        4'd3:    taken = !f_z;
        4'd4:    taken = f_c;
        4'd5:    taken = !f_c;
        4'd6:    taken = !f_s;
        4'd7:    taken = !f_s && !f_z;
        4'd8:    taken = f_s || f_z;
        4'd9:    taken = f_v;
        4'd10:   taken = !f_v;
        4'd11:   taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      ill_q   <= 1'b0;
      flags_q <= 4'd0;
    end else begin
      if (flag_we) flags_q <= flags_in;
      ill_q <= accept && illegal;
      case (state_q)
        IDLE: begin
          if (accept && taken) begin
            rv_q    <= 1'b1;
            rpc_q   <= target;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (bus.pc_ready) begin
            rv_q    <= 1'b0;
            flush_q <= 1'b1;
            cnt_q   <= 4'(FLUSH_CYCLES - 1);
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] res_q;
  logic [31:0] tkn_q;

  assign stat_resolved = res_q;
  assign stat_taken    = tkn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      tkn_q <= '0;
    end else begin
      if (accept && bus.br_cond != '0 && res_q != '1)
        res_q <= res_q + 32'd1;
      if (state_q == HOLD && bus.pc_ready && tkn_q != '1)
        tkn_q <= tkn_q + 32'd1;
    end
  end
`endif

endmodule
